// File: rtl/spi_work_ctrl.sv
// spi_work_ctrl: SPI command front-end for the miner core.
// Loads 44-byte jobs and returns golden nonces behind a status byte.
module spi_work_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         ss,
   input  logic         byte_done,
   input  logic [7:0]   rx_byte,
   output logic [7:0]   tx_byte,
   output logic         work_valid,
   input  logic         work_ready,
   output logic [255:0] midstate,
   output logic [95:0]  work_data,
   input  logic         nonce_valid,
   input  logic [31:0]  nonce
);

   localparam logic [7:0] CMD_WRITE_WORK = 8'h01;
   localparam logic [7:0] CMD_READ_NONCE = 8'h02;
   localparam logic [7:0] CMD_CLEAR      = 8'h03;

   localparam logic [5:0] WORK_LAST  = 6'd43;
   localparam logic [5:0] NONCE_LAST = 6'd3;

   typedef enum logic [1:0] {
      IDLE,
      WR_WORK,
      RD_NONCE,
      DISCARD
   } state_t;

   state_t         state_q, state_d;
   logic           ss_q;
   logic [5:0]     cnt_q, cnt_d;
   logic [351:0]   job_q, job_d;
   logic           work_valid_q, work_valid_d;
   logic [31:0]    nonce_reg_q, nonce_reg_d;
   logic           nonce_pending_q, nonce_pending_d;
   logic           overflow_q, overflow_d;
   logic           stage_valid_q, stage_valid_d;
   logic [31:0]    stage_nonce_q, stage_nonce_d;
   logic           stage_lost_q, stage_lost_d;
   logic [7:0]     tx_byte_q, tx_byte_d;

   logic           job_load;
   logic           nonce_clr;
   logic           rd_exit;
   logic [7:0]     status_d;

   // Frame sequencing: command decode, job shifting and byte counting.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      job_d     = job_q;
      job_load  = 1'b0;
      nonce_clr = 1'b0;
      if (ss_q) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (byte_done) begin
         unique case (state_q)
            IDLE: begin
               cnt_d = '0;
               case (rx_byte)
                  CMD_WRITE_WORK: begin
                     state_d = work_valid_q ? DISCARD : WR_WORK;
                  end
                  CMD_READ_NONCE: begin
                     state_d = RD_NONCE;
                  end
                  CMD_CLEAR: begin
                     nonce_clr = 1'b1;
                     state_d   = DISCARD;
                  end
                  default: begin
                     state_d = DISCARD;
                  end
               endcase
            end
            WR_WORK: begin
               job_d = {job_q[343:0], rx_byte};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == WORK_LAST) begin
                  job_load = 1'b1;
                  state_d  = DISCARD;
               end
            end
            RD_NONCE: begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == NONCE_LAST) begin
                  nonce_clr = 1'b1;
                  state_d   = DISCARD;
               end
            end
            DISCARD: begin
               state_d = DISCARD;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Job handshake: hold the job until the core accepts it.
   always_comb begin
      work_valid_d = work_valid_q;
      if (work_valid_q && work_ready) begin
         work_valid_d = 1'b0;
      end
      if (job_load) begin
         work_valid_d = 1'b1;
      end
   end

   // Nonce capture; arrivals during a read wait in the stage until exit.
   always_comb begin
      nonce_reg_d     = nonce_reg_q;
      nonce_pending_d = nonce_pending_q;
      overflow_d      = overflow_q;
      stage_valid_d   = stage_valid_q;
      stage_nonce_d   = stage_nonce_q;
      stage_lost_d    = stage_lost_q;
      rd_exit = (state_q == RD_NONCE) && (state_d != RD_NONCE);
      if (nonce_clr) begin
         nonce_pending_d = 1'b0;
         overflow_d      = 1'b0;
      end
      if (stage_valid_q && rd_exit) begin
         nonce_reg_d     = stage_nonce_q;
         overflow_d      = overflow_d | nonce_pending_d | stage_lost_q;
         nonce_pending_d = 1'b1;
         stage_valid_d   = 1'b0;
         stage_lost_d    = 1'b0;
      end
      if (nonce_valid) begin
         if ((state_q == RD_NONCE) && !rd_exit) begin
            stage_nonce_d = nonce;
            stage_lost_d  = stage_lost_q | stage_valid_q;
            stage_valid_d = 1'b1;
         end else begin
            nonce_reg_d     = nonce;
            overflow_d      = nonce_clr ? 1'b0 :
                              (overflow_d | nonce_pending_d);
            nonce_pending_d = 1'b1;
         end
      end
   end

   // Response byte: nonce bytes during a read, status otherwise.
   always_comb begin
      status_d = {nonce_pending_d, work_valid_d, 4'b0000,
                  overflow_d, 1'b1};
      tx_byte_d = status_d;
      if (state_d == RD_NONCE) begin
         tx_byte_d = tx_byte_q;
         if (byte_done && !ss_q) begin
            if (state_q == IDLE) begin
               tx_byte_d = nonce_reg_d[31:24];
            end else begin
               case (cnt_q)
                  6'd0:    tx_byte_d = nonce_reg_d[23:16];
                  6'd1:    tx_byte_d = nonce_reg_d[15:8];
                  6'd2:    tx_byte_d = nonce_reg_d[7:0];
                  default: tx_byte_d = status_d;
               endcase
            end
         end
      end
   end

   // State register; reset wins over every other event.
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_q            <= 1'b1;
         state_q         <= IDLE;
         cnt_q           <= '0;
         job_q           <= '0;
         work_valid_q    <= 1'b0;
         nonce_reg_q     <= '0;
         nonce_pending_q <= 1'b0;
         overflow_q      <= 1'b0;
         stage_valid_q   <= 1'b0;
         stage_nonce_q   <= '0;
         stage_lost_q    <= 1'b0;
         tx_byte_q       <= 8'h01;
      end else begin
         ss_q            <= ss;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         job_q           <= job_d;
         work_valid_q    <= work_valid_d;
         nonce_reg_q     <= nonce_reg_d;
         nonce_pending_q <= nonce_pending_d;
         overflow_q      <= overflow_d;
         stage_valid_q   <= stage_valid_d;
         stage_nonce_q   <= stage_nonce_d;
         stage_lost_q    <= stage_lost_d;
         tx_byte_q       <= tx_byte_d;
      end
   end

   assign tx_byte    = tx_byte_q;
   assign work_valid = work_valid_q;
   assign midstate   = job_q[351:96];
   assign work_data  = job_q[95:0];

endmodule

// File: tb/tb_spi_work_ctrl.sv
// tb_spi_work_ctrl: scoreboard bench for spi_work_ctrl.
// Models the byte-level slave that loads tx_byte at byte completion.
module tb_spi_work_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         ss;
   logic         byte_done;
   logic [7:0]   rx_byte;
   logic [7:0]   tx_byte;
   logic         work_valid;
   logic         work_ready;
   logic [255:0] midstate;
   logic [95:0]  work_data;
   logic         nonce_valid;
   logic [31:0]  nonce;

   int checks = 0;
   int errors = 0;
   logic [7:0] sbq[$];
   logic [7:0] shreg;

   always #5 clk = ~clk;

   spi_work_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .ss          (ss),
      .byte_done   (byte_done),
      .rx_byte     (rx_byte),
      .tx_byte     (tx_byte),
      .work_valid  (work_valid),
      .work_ready  (work_ready),
      .midstate    (midstate),
      .work_data   (work_data),
      .nonce_valid (nonce_valid),
      .nonce       (nonce)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame_begin();
      ss = 1'b0;
      tick(2);
      shreg = tx_byte;
   endtask

   task automatic frame_end();
      ss = 1'b1;
      tick(2);
   endtask

   // One SPI byte: master receives shreg, slave reloads it from tx_byte.
   task automatic spi_byte(input logic [7:0] b, input bit rd);
      logic [7:0] got;
      logic [7:0] exp;
      got       = shreg;
      rx_byte   = b;
      byte_done = 1'b1;
      shreg     = tx_byte;
      tick(1);
      byte_done = 1'b0;
      tick(2);
      if (rd) begin
         exp = 8'hxx;
         if (sbq.size() > 0) exp = sbq.pop_front();
         chk("miso", got, exp);
      end
   endtask

   task automatic pulse_nonce(input logic [31:0] v);
      nonce       = v;
      nonce_valid = 1'b1;
      tick(1);
      nonce_valid = 1'b0;
      tick(1);
   endtask

   task automatic push7(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input logic [7:0] e, input logic [7:0] f,
                        input logic [7:0] g);
      sbq.push_back(a);
      sbq.push_back(b);
      sbq.push_back(c);
      sbq.push_back(d);
      sbq.push_back(e);
      sbq.push_back(f);
      sbq.push_back(g);
   endtask

   task automatic read_frame();
      frame_begin();
      spi_byte(8'h02, 1'b1);
      for (int i = 0; i < 6; i++) spi_byte(8'h00, 1'b1);
      frame_end();
      chk("sb_empty", sbq.size(), 0);
   endtask

   initial begin
      rst         = 1'b1;
      ss          = 1'b1;
      byte_done   = 1'b0;
      rx_byte     = 8'h00;
      work_ready  = 1'b0;
      nonce_valid = 1'b0;
      nonce       = 32'h0;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_tx", tx_byte, 8'h01);
      chk("rst_wv", work_valid, 0);
      chk("rst_ms", midstate[255:224], 32'h0);
      chk("rst_wd", work_data[31:0], 32'h0);

      // full job load, one trailing byte ignored
      frame_begin();
      spi_byte(8'h01, 1'b0);
      for (int i = 0; i < 44; i++) begin
         spi_byte(8'(i), 1'b0);
         if (i == 42) chk("wv_early", work_valid, 0);
      end
      chk("wv_set", work_valid, 1);
      spi_byte(8'hFF, 1'b0);
      frame_end();
      chk("wr_ms_b1", midstate[255:248], 8'h00);
      chk("wr_ms_b2", midstate[247:240], 8'h01);
      chk("wr_ms_b32", midstate[7:0], 8'h1F);
      chk("wr_wd_b33", work_data[95:88], 8'h20);
      chk("wr_wd_b44", work_data[7:0], 8'h2B);
      chk("wr_status", tx_byte, 8'h41);

      // second job while one is pending is rejected
      frame_begin();
      spi_byte(8'h01, 1'b0);
      for (int i = 0; i < 44; i++) spi_byte(8'hAA, 1'b0);
      frame_end();
      chk("rej_wv", work_valid, 1);
      chk("rej_ms", midstate[255:248], 8'h00);
      chk("rej_wd", work_data[7:0], 8'h2B);

      // accept
      work_ready = 1'b1;
      tick(1);
      work_ready = 1'b0;
      chk("acc_wv", work_valid, 0);
      chk("acc_tx", tx_byte, 8'h01);

      // nonce read
      pulse_nonce(32'hDEADBEEF);
      chk("nv_tx", tx_byte, 8'h81);
      push7(8'h81, 8'h81, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01);
      read_frame();
      chk("rd_tx", tx_byte, 8'h01);

      // overflow and clear
      pulse_nonce(32'h11111111);
      pulse_nonce(32'h22222222);
      chk("ovf_tx", tx_byte, 8'h83);
      frame_begin();
      spi_byte(8'h03, 1'b0);
      chk("clr_in", tx_byte, 8'h01);
      frame_end();
      chk("clr_tx", tx_byte, 8'h01);

      // nonce arriving mid-read is staged, then applied on exit
      pulse_nonce(32'h12345678);
      push7(8'h81, 8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h81);
      frame_begin();
      spi_byte(8'h02, 1'b1);
      spi_byte(8'h00, 1'b1);
      spi_byte(8'h00, 1'b1);
      pulse_nonce(32'hCAFEF00D);
      for (int i = 0; i < 4; i++) spi_byte(8'h00, 1'b1);
      frame_end();
      chk("stg_sb", sbq.size(), 0);
      chk("stg_tx", tx_byte, 8'h81);
      push7(8'h81, 8'h81, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h01);
      read_frame();

      // aborted job load, then a clean one
      frame_begin();
      spi_byte(8'h01, 1'b0);
      for (int i = 0; i < 20; i++) spi_byte(8'(i + 128), 1'b0);
      frame_end();
      chk("abt_wv", work_valid, 0);
      chk("abt_tx", tx_byte, 8'h01);
      frame_begin();
      spi_byte(8'h01, 1'b0);
      for (int i = 0; i < 44; i++) spi_byte(8'(i + 64), 1'b0);
      frame_end();
      chk("re_wv", work_valid, 1);
      chk("re_ms_b1", midstate[255:248], 8'h40);
      chk("re_ms_b2", midstate[247:240], 8'h41);
      chk("re_wd_b44", work_data[7:0], 8'h6B);
      work_ready = 1'b1;
      tick(1);
      work_ready = 1'b0;
      chk("re_acc", work_valid, 0);

      // aborted read keeps the nonce pending
      pulse_nonce(32'hA5A5A5A5);
      sbq.push_back(8'h81);
      sbq.push_back(8'h81);
      sbq.push_back(8'hA5);
      frame_begin();
      spi_byte(8'h02, 1'b1);
      spi_byte(8'h00, 1'b1);
      spi_byte(8'h00, 1'b1);
      frame_end();
      chk("abr_tx", tx_byte, 8'h81);

      // reset beats a simultaneous nonce
      rst         = 1'b1;
      nonce       = 32'h55555555;
      nonce_valid = 1'b1;
      tick(1);
      rst         = 1'b0;
      nonce_valid = 1'b0;
      tick(1);
      chk("rp_tx", tx_byte, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
